// File: rtl/somador_arbiter_if.sv
`timescale 1ns/1ps
// somador_arbiter_if
// Bundles the requester-side handshake and result bus of somador_arbiter.
//   req0/req1        : operation requests from requester 0 / 1
//   a0,b0 / a1,b1    : 4-bit operands, held stable while the matching req is high
//   gnt0/gnt1        : one-cycle grant pulses (operands captured)
//   busy             : arbiter is computing or holding a result
//   done, done_id    : one-cycle result-valid pulse and the requester it served
//   cout,sum         : 5-bit sum split as carry + low nibble
//   tens,units       : decimal digits of the 5-bit sum, for the 7-segment decoders
// Modports: slave = the arbiter, master = the requester/display side.
interface somador_arbiter_if;
  logic       req0;
  logic       req1;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic       done;
  logic       done_id;
  logic       cout;
  logic [3:0] sum;
  logic [3:0] tens;
  logic [3:0] units;

  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    output gnt0, gnt1, busy, done, done_id, cout, sum, tens, units
  );

  modport master (
    output req0, req1, a0, b0, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, cout, sum, tens, units
  );
endinterface

// File: rtl/somador_arbiter.sv
`timescale 1ns/1ps
// somador_arbiter
// Round-robin arbiter sharing one 4-bit adder (with decimal digit split)
// between two requesters. A request seen in IDLE is granted, the operands are
// added on the following edge, and the result is then shown for SHOW_CYCLES
// cycles before the next request can be served.
// Parameters:
//   SHOW_CYCLES : cycles spent in HOLD after each result (1 .. 65535)
//   RR_INIT     : requester that wins the first tie after reset (0 or 1)
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : somador_arbiter_if.slave (requests, operands, grants, results)
module somador_arbiter #(
  parameter int SHOW_CYCLES = 4,
  parameter int RR_INIT     = 0
) (
  input logic              clk,
  input logic              rst,
  somador_arbiter_if.slave bus
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_ADD  = 2'd1;
  localparam logic [1:0]  ST_HOLD = 2'd2;

  localparam logic [15:0] DWELL_LOAD = 16'(SHOW_CYCLES - 1);
  // The pointer remembers who was served last, so starting it at the other
  // requester makes RR_INIT the winner of the first tie.
  localparam logic        PTR_RESET  = (RR_INIT == 0) ? 1'b1 : 1'b0;

  logic [1:0]  state;
  logic [15:0] dwell_cnt;
  logic        last_served;

  logic [3:0]  op_a;
  logic [3:0]  op_b;
  logic        op_id;

  logic        gnt0_q;
  logic        gnt1_q;
  logic        done_q;
  logic        done_id_q;
  logic        cout_q;
  logic [3:0]  sum_q;
  logic [3:0]  tens_q;
  logic [3:0]  units_q;

  logic        any_req;
  logic        winner;
  logic [4:0]  add_result;
  logic [3:0]  tens_next;
  logic [3:0]  units_next;

  assign any_req = bus.req0 | bus.req1;

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      winner = ~last_served;
    end else if (bus.req1) begin
      winner = 1'b1;
    end
  end

  assign add_result = {1'b0, op_a} + {1'b0, op_b};

  // The sum never exceeds 30, so the decimal split is a short compare chain
  // rather than a divider.
  always_comb begin
    tens_next  = 4'd0;
    units_next = 4'(add_result);
    if (add_result >= 5'd30) begin
      tens_next  = 4'd3;
      units_next = 4'(add_result - 5'd30);
    end else if (add_result >= 5'd20) begin
      tens_next  = 4'd2;
      units_next = 4'(add_result - 5'd20);
    end else if (add_result >= 5'd10) begin
      tens_next  = 4'd1;
      units_next = 4'(add_result - 5'd10);
    end
  end

  // Sequencer: grant in IDLE, compute in ADD, dwell in HOLD. Grant and done
  // default low every cycle so they are single-cycle registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dwell_cnt   <= 16'd0;
      last_served <= PTR_RESET;
      op_a        <= 4'd0;
      op_b        <= 4'd0;
      op_id       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      cout_q      <= 1'b0;
      sum_q       <= 4'd0;
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            op_a        <= winner ? bus.a1 : bus.a0;
            op_b        <= winner ? bus.b1 : bus.b0;
            op_id       <= winner;
            last_served <= winner;
            gnt0_q      <= ~winner;
            gnt1_q      <= winner;
            state       <= ST_ADD;
          end
        end
        ST_ADD: begin
          cout_q    <= add_result[4];
          sum_q     <= add_result[3:0];
          tens_q    <= tens_next;
          units_q   <= units_next;
          done_id_q <= op_id;
          done_q    <= 1'b1;
          dwell_cnt <= DWELL_LOAD;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (dwell_cnt == 16'd0) begin
            state <= ST_IDLE;
          end else begin
            dwell_cnt <= dwell_cnt - 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = (state == ST_ADD) || (state == ST_HOLD);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.cout    = cout_q;
  assign bus.sum     = sum_q;
  assign bus.tens    = tens_q;
  assign bus.units   = units_q;

endmodule

// File: tb/tb_somador_arbiter.sv
`timescale 1ns/1ps
// tb_somador_arbiter
// Directed self-checking bench for somador_arbiter. One instance uses the
// default dwell (SHOW_CYCLES=4), a second uses SHOW_CYCLES=1. Inputs change
// 1 ns after a rising edge; outputs are sampled at the same point.
module tb_somador_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  somador_arbiter_if bus ();
  somador_arbiter_if bus_fast ();

  somador_arbiter #(.SHOW_CYCLES(4), .RR_INIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  somador_arbiter #(.SHOW_CYCLES(1), .RR_INIT(0)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (bus_fast)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic r1,
                               input logic [3:0] x0, input logic [3:0] y0,
                               input logic [3:0] x1, input logic [3:0] y1);
    bus.req0 = r0;
    bus.req1 = r1;
    bus.a0   = x0;
    bus.b0   = y0;
    bus.a1   = x1;
    bus.b1   = y1;
  endtask

  task automatic checkResult(input string tag, input logic id, input logic c,
                             input logic [3:0] s, input logic [3:0] t, input logic [3:0] u);
    checkOutput({tag, "_done"},    32'(bus.done),    32'd1);
    checkOutput({tag, "_done_id"}, 32'(bus.done_id), 32'(id));
    checkOutput({tag, "_cout"},    32'(bus.cout),    32'(c));
    checkOutput({tag, "_sum"},     32'(bus.sum),     32'(s));
    checkOutput({tag, "_tens"},    32'(bus.tens),    32'(t));
    checkOutput({tag, "_units"},   32'(bus.units),   32'(u));
  endtask

  task automatic checkCleared(input string tag);
    checkOutput(tag, 32'({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id,
                          bus.cout, bus.sum, bus.tens, bus.units}), 32'd0);
  endtask

  initial begin
    int g_count;
    int d_count;
    int bad;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    bus_fast.req0 = 1'b0;
    bus_fast.req1 = 1'b0;
    bus_fast.a0   = 4'd0;
    bus_fast.b0   = 4'd0;
    bus_fast.a1   = 4'd0;
    bus_fast.b1   = 4'd0;
    tick();
    tick();
    checkCleared("reset_outputs");
    rst = 1'b0;

    // Single request: 7 + 5 = 12
    applyStimulus(1'b1, 1'b0, 4'd7, 4'd5, 4'd0, 4'd0);
    tick();
    checkOutput("single_gnt0", 32'(bus.gnt0), 32'd1);
    checkOutput("single_gnt1", 32'(bus.gnt1), 32'd0);
    checkOutput("single_busy", 32'(bus.busy), 32'd1);
    checkOutput("single_nodone", 32'(bus.done), 32'd0);
    bus.req0 = 1'b0;
    tick();
    checkOutput("single_gnt0_drop", 32'(bus.gnt0), 32'd0);
    checkResult("single", 1'b0, 1'b0, 4'd12, 4'd1, 4'd2);
    tick();
    checkOutput("single_done_pulse", 32'(bus.done), 32'd0);
    tick();
    tick();
    checkOutput("single_busy_hold", 32'(bus.busy), 32'd1);
    tick();
    checkOutput("single_busy_end", 32'(bus.busy), 32'd0);
    checkOutput("single_sum_held", 32'(bus.sum), 32'd12);

    // Tie after reset: requester 0 wins first, requester 1 six cycles later
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'd10, 4'd11, 4'd3, 4'd4);
    tick();
    checkOutput("tie_first_gnt0", 32'(bus.gnt0), 32'd1);
    checkOutput("tie_first_gnt1", 32'(bus.gnt1), 32'd0);
    bus.req0 = 1'b0;
    tick();
    checkResult("tie_first", 1'b0, 1'b1, 4'd5, 4'd2, 4'd1);
    tick();
    tick();
    tick();
    tick();
    checkOutput("tie_early_gnt1", 32'(bus.gnt1), 32'd0);
    tick();
    checkOutput("tie_second_gnt1", 32'(bus.gnt1), 32'd1);
    checkOutput("tie_second_gnt0", 32'(bus.gnt0), 32'd0);
    bus.req1 = 1'b0;
    tick();
    checkResult("tie_second", 1'b1, 1'b0, 4'd7, 4'd0, 4'd7);

    // Maximum operands: 15 + 15 = 30
    tick();
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd15, 4'd15);
    tick();
    checkOutput("max_gnt1", 32'(bus.gnt1), 32'd1);
    bus.req1 = 1'b0;
    tick();
    checkResult("max", 1'b1, 1'b1, 4'd14, 4'd3, 4'd0);

    // Request pulsed during HOLD is ignored
    tick();
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 4'd1);
    tick();
    bus.req1 = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.gnt0 || bus.gnt1 || bus.done) bad++;
    end
    checkOutput("busy_req_ignored", 32'(bad), 32'd0);
    checkOutput("busy_req_sum_held", 32'(bus.sum), 32'd14);
    checkOutput("busy_req_units_held", 32'(bus.units), 32'd0);

    // Reset two cycles after done aborts the operation
    applyStimulus(1'b1, 1'b0, 4'd2, 4'd3, 4'd0, 4'd0);
    tick();
    checkOutput("rst_hold_gnt0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 1'b0;
    tick();
    checkResult("rst_hold_pre", 1'b0, 1'b0, 4'd5, 4'd0, 4'd5);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkCleared("rst_hold_cleared");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd4, 4'd4);
    tick();
    checkOutput("rst_hold_gnt1", 32'(bus.gnt1), 32'd1);
    bus.req1 = 1'b0;
    tick();
    checkResult("rst_hold_post", 1'b1, 1'b0, 4'd8, 4'd0, 4'd8);

    // Continuous contention from reset: 0,1,0,1... every 6 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    g_count = 0;
    bad = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.gnt0 && bus.gnt1) bad++;
      if (bus.done && (bus.gnt0 || bus.gnt1)) bad++;
      if (bus.gnt0 || bus.gnt1) begin
        checkOutput("rr_id", 32'(bus.gnt1), 32'(g_count % 2));
        checkOutput("rr_cycle", 32'(c), 32'(1 + 6 * g_count));
        g_count++;
      end
    end
    checkOutput("rr_count", 32'(g_count), 32'd7);
    checkOutput("rr_overlap", 32'(bad), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

    // SHOW_CYCLES=1: a held request is served every 3 cycles
    bus_fast.req0 = 1'b1;
    bus_fast.a0   = 4'd9;
    bus_fast.b0   = 4'd9;
    g_count = 0;
    d_count = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus_fast.gnt0 || bus_fast.gnt1) begin
        checkOutput("fast_gnt_cycle", 32'(c), 32'(1 + 3 * g_count));
        g_count++;
      end
      if (bus_fast.done) begin
        checkOutput("fast_result", 32'({bus_fast.done_id, bus_fast.cout, bus_fast.sum,
                                        bus_fast.tens, bus_fast.units}),
                    32'({1'b0, 1'b1, 4'd2, 4'd1, 4'd8}));
        d_count++;
      end
    end
    checkOutput("fast_gnt_count", 32'(g_count), 32'd4);
    checkOutput("fast_done_count", 32'(d_count), 32'd3);
    bus_fast.req0 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/somador_arbiter.md
# somador_arbiter

Round-robin arbiter and sequencer that shares one 4-bit adder, with its binary-to-decimal digit split, between two requesters. Each requester presents two operands with a request. The block grants one requester, computes the 5-bit sum plus the tens and units digits, and holds the result for a fixed display dwell before it serves the next request. Downstream, `tens` and `units` feed the `dcba27segments` decoders, and `done`/`done_id` feed the requesters.

## Interface
- `SHOW_CYCLES`, default 4: number of cycles the block stays in HOLD after each result; legal range 1 to 2^16-1.
- `RR_INIT`, default 0: requester that wins the first tie after reset (0 or 1).

- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req0`, `req1`  in  1 each  operation request from requester 0 or 1.
- `a0`, `b0`  in  4 each  operands of requester 0; must be stable while `req0` is high.
- `a1`, `b1`  in  4 each  operands of requester 1; must be stable while `req1` is high.
- `gnt0`, `gnt1`  out  1 each  one-cycle pulse: operands captured for that requester.
- `busy`  out  1  high in ADD and HOLD.
- `done`  out  1  one-cycle pulse: result outputs updated.
- `done_id`  out  1  requester served by the latest result.
- `cout`  out  1  bit 4 of the latest sum.
- `sum`  out  4  bits 3:0 of the latest sum.
- `tens`  out  4  latest sum / 10 (range 0–3).
- `units`  out  4  latest sum % 10 (range 0–9).

## Operation
- **States:**
  - IDLE → ADD, when any request is sampled.
  - ADD → HOLD, always.
  - HOLD → IDLE, when the dwell counter is 0; otherwise the counter decrements.
- **Arbitration (IDLE only):**
  - Only one req high: that requester wins.
  - Both high: the requester not served last wins.
  - The last-served pointer resets to `!RR_INIT`, so `RR_INIT` wins the first tie.
  - The pointer updates at grant time.
- **Grant edge:**
  - Latch the winner's a/b into internal operand registers.
  - Latch the winner's id.
  - Assert that requester's gnt for exactly one cycle.
- **ADD edge:** compute a 5-bit sum {cout, sum} = a + b with zero-extended operands, no truncation. Register:
  - `cout`, `sum`
  - `tens` = sum/10 and `units` = sum%10, both from the 5-bit value
  - `done_id`
  - `done` = 1
  - dwell counter = `SHOW_CYCLES`-1
- **Result hold:** result outputs hold their value until the next ADD edge. They are not cleared in IDLE.
- **Requests during ADD or HOLD:** ignored, never queued, and no gnt is issued. A req still high when IDLE is re-entered is arbitrated as a new request.
- **Requester obligation:** drop req in the cycle its gnt is high. A req left high is treated as a further request.
- **Reset:**
  - All outputs go to 0.
  - State goes to IDLE, the counter to 0, the pointer to `!RR_INIT`.
  - Reset during ADD or HOLD aborts the operation: no done is issued for it, and the captured operands are discarded.

## Timing
- Request sampled high at edge E0 in IDLE:
  - gnt high during cycle E0–E1.
  - done, result outputs and `done_id` valid from E1.
  - done high for the single cycle E1–E2.
- `busy` is high from E0 until the edge that returns the block to IDLE, E1+`SHOW_CYCLES`.
- Earliest next grant is edge E2+`SHOW_CYCLES`, so the minimum grant-to-grant spacing is `SHOW_CYCLES`+2 cycles (6 with the default).
- gnt and done are registered outputs with no combinational path from inputs.
- gnt0 and gnt1 are never high together. done and any gnt are never high in the same cycle.

## Test plan
- **Single request:** `rst` for 2 cycles, then `req0`=1, a0=7, b0=5 → gnt0 pulse next cycle; done one cycle later with `done_id`=0, `cout`=0, `sum`=1100, `tens`=1, `units`=2; `busy` low again 4 cycles after done.
- **Tie after reset (`RR_INIT`=0):** `req0` and `req1` both high with a0=10, b0=11, a1=3, b1=4, each requester holding req until its own gnt → first result `done_id`=0, `cout`=1, `sum`=0101, `tens`=2, `units`=1; second result `done_id`=1, `sum`=0111, `tens`=0, `units`=7; grant spacing 6 cycles.
- **Maximum operands:** a1=15, b1=15 → `cout`=1, `sum`=1110, `tens`=3, `units`=0.
- **Continuous contention:** both reqs held high for 40 cycles → gnt strictly alternates 0,1,0,1…; the first grant goes to 0; gnt edges exactly 6 cycles apart; gnt0 and gnt1 never overlap.
- **Request while busy:** `req1` pulsed for one cycle during HOLD → no gnt1 and results unchanged.
- **Reset during HOLD:** `rst` asserted 2 cycles after done → next cycle all outputs 0 and `busy`=0; `req1`=1 afterward → gnt1, with `done_id`=1 on its result.
- **SHOW_CYCLES=1:** single requests → grant spacing 3 cycles.
